bist_engine: RTL
================

# bist_engine

Parametrised logic-BIST engine: an LFSR pattern generator drives a circuit under test (CUT), and a MISR compacts the CUT responses into a signature. The engine runs a fixed pattern count on request and compares the result against a golden signature. It replaces the fixed-width, free-running BIST with start/done handshaking, configurable CUT latency and a pass/fail verdict. It sits between the test-mode controller and the CUT wrapper.

## Interface
- `WIDTH`, 8: LFSR, pattern, response and MISR width (≥2).
- `NUM_PATTERNS`, 255: patterns per run (≥1).
- `LFSR_TAPS`, 8'hB8: feedback mask for the pattern LFSR.
- `MISR_TAPS`, 8'hB8: feedback mask for the MISR.
- `SEED`, 1: LFSR seed. 0 is illegal; the engine substitutes 1.
- `CUT_LAT`, 0: cycles from `pattern_o` to matching `resp_i` (0 = combinational CUT).
- `GOLDEN`, 0: expected final signature.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle run request.
- `resp_i` in WIDTH: CUT response.
- `pattern_o` out WIDTH: pattern to the CUT.
- `pattern_vld_o` out 1: `pattern_o` is a live test pattern.
- `busy_o` out 1: run in progress.
- `done_o` out 1: result valid; held until the next start or reset.
- `pass_o` out 1: signature equals `GOLDEN`; meaningful only while `done_o` is 1.
- `signature_o` out WIDTH: current MISR contents.

## Operation
- Reset values: state IDLE, LFSR=SEED, MISR=0, counter=0. All outputs 0 except `pattern_o`=SEED.
- LFSR step: Fibonacci, shift left. New bit0 = XOR of `state & LFSR_TAPS`.
- MISR step when a response is valid: `{misr[W-2:0], ^(misr & MISR_TAPS)} ^ resp_i`.
- FSM states:
  - **IDLE**: when `start_i` is 1, reload LFSR=SEED and MISR=0, then go to RUN.
  - **RUN**: `pattern_vld_o`=1. The LFSR advances every cycle and the counter counts patterns issued. After pattern NUM_PATTERNS-1 is presented, go to DRAIN, or to DONE if CUT_LAT=0.
  - **DRAIN**: `pattern_vld_o`=0 and the LFSR holds. Stay CUT_LAT cycles while in-flight responses are compacted, then go to DONE.
  - **DONE**: `done_o`=1, `pass_o`=(misr==GOLDEN), MISR frozen. `start_i` restarts exactly as from IDLE.
- Response tracking: a CUT_LAT-deep valid shift register marks which cycles carry a response. Only marked cycles update the MISR; `resp_i` is ignored otherwise.
- `start_i` during RUN or DRAIN is ignored.
- `rst` in any state, including mid-run, returns to the reset values on the next edge. No partial result is reported.
- `busy_o`=1 in RUN and DRAIN.

## Timing
- `start_i` sampled high at edge t:
  - From cycle t+1, `busy_o`=1, `pattern_vld_o`=1 and `pattern_o`=SEED.
  - Pattern k is presented in cycle t+1+k.
  - The response for pattern k is sampled at the end of cycle t+1+k+CUT_LAT.
- `done_o` rises in cycle t+1+NUM_PATTERNS+CUT_LAT. `busy_o` falls in the same cycle.
- Restart from DONE follows the same timing. `done_o` and `pass_o` clear in cycle t+1.
- The LFSR wraps naturally at period 2^WIDTH-1. NUM_PATTERNS larger than the period repeats patterns; this is legal.

## Structure
- `bist_pkg` holds:
  - the `bist_state_e` enum (IDLE, RUN, DRAIN, DONE);
  - the default tap constants per width (4: 4'hC, 8: 8'hB8, 16: 16'hB400).
- Sub-module `bist_lfsr`, parameters WIDTH and TAPS:
  - inputs `load`, `seed`, `en`, `data_en`, `data`;
  - used once as the pattern LFSR (`data_en`=0) and once as the MISR (`data_en`=1).
- Counter width is `$clog2(NUM_PATTERNS+1)`.

## Test plan
All scenarios use WIDTH=4, LFSR_TAPS=MISR_TAPS=4'hC, SEED=1 unless stated.
- Free-run the LFSR with NUM_PATTERNS=15 -> `pattern_o` sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8.
- Identity CUT (`resp_i`=`pattern_o`), CUT_LAT=0, NUM_PATTERNS=3, GOLDEN=4'h4 -> `signature_o`=4'h4, `pass_o`=1, `done_o` in cycle t+4.
- Same as above with `resp_i[0]` stuck at 0 -> `signature_o`=4'h0, `pass_o`=0.
- Identity CUT delayed by CUT_LAT=2, NUM_PATTERNS=3 -> `signature_o`=4'h4, `done_o` in cycle t+6, `pattern_vld_o` low during the two DRAIN cycles.
- `start_i` pulsed mid-RUN -> ignored and timing unchanged. `rst` mid-RUN -> all outputs at reset values next cycle. A following `start_i` -> full correct run.
- Restart from DONE with a different CUT fault -> `done_o` drops for the run and `pass_o` reflects the new run only.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and default feedback masks for the logic-BIST engine.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  function automatic logic [31:0] default_taps(input int w);
    case (w)
      4:       return 32'(TAPS_W4);
      16:      return 32'(TAPS_W16);
      default: return 32'(TAPS_W8);
    endcase
  endfunction

endpackage

// File: rtl/bist_if.sv
// Handshake and data bundle between test controller, BIST engine and CUT.
interface bist_if #(
  parameter int WIDTH = 8
) ();

  logic             start_i;
  logic [WIDTH-1:0] resp_i;
  logic [WIDTH-1:0] pattern_o;
  logic             pattern_vld_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [WIDTH-1:0] signature_o;

  modport master (
    output start_i, resp_i,
    input  pattern_o, pattern_vld_o, busy_o,
    input  done_o, pass_o, signature_o
  );

  modport slave (
    input  start_i, resp_i,
    output pattern_o, pattern_vld_o, busy_o,
    output done_o, pass_o, signature_o
  );

endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci shift-left LFSR; with data_en set it becomes a MISR.
module bist_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             data_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = {state[WIDTH-2:0], ^(state & TAPS)};
    if (data_en) nxt = nxt ^ data;
  end

  always_ff @(posedge clk) begin
    if (rst || load) state <= seed;
    else if (en)     state <= nxt;
  end

endmodule

// File: rtl/bist_engine.sv
// Logic BIST: LFSR patterns out, MISR-compacted responses in, golden verdict.
module bist_engine
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NUM_PATTERNS = 255,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] MISR_TAPS    = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(1),
  parameter int               CUT_LAT      = 0,
  parameter logic [WIDTH-1:0] GOLDEN       = '0
) (
  input logic   clk,
  input logic   rst,
  bist_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam int DW    = (CUT_LAT > 1) ? $clog2(CUT_LAT) : 1;
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == '0) ? WIDTH'(1) : SEED;

  bist_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             run;
  logic             restart;
  logic             last;
  logic             drained;
  logic             resp_vld;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;

  assign run     = (state == RUN);
  assign restart = bus.start_i && (state == IDLE || state == DONE);
  assign last    = (cnt == CNT_W'(NUM_PATTERNS - 1));
  assign drained = (dcnt == DW'(CUT_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (restart) begin
            state <= RUN;
            cnt   <= '0;
            dcnt  <= '0;
          end
        end
        RUN: begin
          if (last) state <= (CUT_LAT == 0) ? DONE : DRAIN;
          else      cnt   <= cnt + 1'b1;
        end
        DRAIN: begin
          if (drained) state <= DONE;
          else         dcnt  <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bit i set means a pattern issued i+1 cycles ago is returning now.
  if (CUT_LAT == 0) begin : g_comb
    assign resp_vld = run;
  end else begin : g_pipe
    logic [CUT_LAT-1:0] vsr;
    always_ff @(posedge clk) begin
      if (rst) vsr <= '0;
      else     vsr <= CUT_LAT'({vsr, run});
    end
    assign resp_vld = vsr[CUT_LAT-1];
  end

  bist_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (restart),
    .seed    (SEED_EFF),
    .en      (run),
    .data_en (1'b0),
    .data    ('0),
    .state   (lfsr)
  );

  bist_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (restart),
    .seed    ('0),
    .en      (resp_vld),
    .data_en (1'b1),
    .data    (bus.resp_i),
    .state   (misr)
  );

  assign bus.pattern_o     = lfsr;
  assign bus.pattern_vld_o = run;
  assign bus.busy_o        = (state == RUN) || (state == DRAIN);
  assign bus.done_o        = (state == DONE);
  assign bus.pass_o        = (state == DONE) && (misr == GOLDEN);
  assign bus.signature_o   = misr;

endmodule
